// File: rtl/bus_mem_responder.sv
// Wait-stated single-port memory responder on a simple level-request bus.
// Optional write protection of the top eighth of the window: BUS_MEM_RESPONDER_WRPROT_EN.

`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

// state  | meaning
// S_IDLE | no transaction owned, watching for a request edge
// S_WAIT | wait counter running down toward the acknowledge
// S_ACK  | done pulse cycle; write commits on the closing edge
module bus_mem_responder #(
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`ADDR_SIZE-1:0] addr_in,
    input  logic [`DATA_SIZE-1:0] data_in,
    output logic [`DATA_SIZE-1:0] data_out,
    input  logic                  read_q,
    input  logic                  write_q,
    output logic                  read_dn,
    output logic                  write_dn,
    input  logic                  rw_halt,
    output logic                  bus_busy,
    output logic                  proto_err
);

    localparam int AW = `ADDR_SIZE;
    localparam int unsigned WIN_LO = BASE_ADDR;
    localparam int unsigned WIN_HI = BASE_ADDR + (1 << DEPTH_LOG2) - 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t state, state_nxt;

    logic [`DATA_SIZE-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    logic                  read_q_d, write_q_d;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  dir_wr_q;
    logic [`DATA_SIZE-1:0] data_q;

    logic [31:0]           addr_ext;
    logic                  in_win;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_rise, wr_rise;
    logic                  accept, both_rise;
    logic                  wr_prot;
    logic                  mem_we;
    logic                  rd_dn_int, wr_dn_int, busy_int;

    assign addr_ext  = 32'(addr_in);
    assign in_win    = (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI);
    assign idx       = DEPTH_LOG2'(addr_in - AW'(BASE_ADDR));
    assign rd_rise   = read_q & ~read_q_d;
    assign wr_rise   = write_q & ~write_q_d;
    assign accept    = (state == S_IDLE) && in_win && !rw_halt && (rd_rise ^ wr_rise);
    assign both_rise = (state == S_IDLE) && in_win && rd_rise && wr_rise;

`ifdef BUS_MEM_RESPONDER_WRPROT_EN
    assign wr_prot = (idx_q[DEPTH_LOG2-1 -: 3] == 3'b111);
`else
    assign wr_prot = 1'b0;
`endif

    assign mem_we = rst && wr_dn_int && !wr_prot;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_WAIT;
            S_WAIT: begin
                if (rw_halt)       state_nxt = S_IDLE;
                else if (cnt == 0) state_nxt = S_ACK;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A halt during the acknowledge cycle suppresses the pulse as well as the write.
    always_comb begin
        rd_dn_int = 1'b0;
        wr_dn_int = 1'b0;
        busy_int  = 1'b0;
        case (state)
            S_WAIT: busy_int = 1'b1;
            S_ACK: begin
                busy_int  = 1'b1;
                rd_dn_int = !dir_wr_q && !rw_halt;
                wr_dn_int = dir_wr_q && !rw_halt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            read_q_d  <= 1'b0;
            write_q_d <= 1'b0;
            cnt       <= 4'd0;
            idx_q     <= '0;
            dir_wr_q  <= 1'b0;
            data_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            read_q_d  <= read_q;
            write_q_d <= write_q;
            if (accept) begin
                cnt      <= 4'(WAIT_STATES);
                idx_q    <= idx;
                dir_wr_q <= wr_rise;
                data_q   <= data_in;
            end else if (state == S_WAIT) begin
                if (rw_halt)       cnt <= 4'd0;
                else if (cnt != 0) cnt <= cnt - 4'd1;
            end
            if (both_rise || (wr_dn_int && wr_prot))
                proto_err <= 1'b1;
        end
    end

    // Storage has no reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= data_q;
    end

    assign read_dn  = rd_dn_int;
    assign write_dn = wr_dn_int;
    assign data_out = rd_dn_int ? mem[idx_q] : {`DATA_SIZE{1'bz}};
    assign bus_busy = busy_int ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: two instances sharing the request bus,
// one with two wait states and one with none, at disjoint address windows.

`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

module tb_bus_mem_responder;

    logic        clk = 1'b0;
    logic        rst, rq, wq, halt;
    logic [15:0] addr, din;

    wire [15:0] dout0, dout1;
    wire        rdn0, wdn0, busy0, perr0;
    wire        rdn1, wdn1, busy1, perr1;

    int checks = 0;
    int errors = 0;
    int npulse;

    always #5 clk = ~clk;

    bus_mem_responder #(.BASE_ADDR(16'h0040), .DEPTH_LOG2(4), .WAIT_STATES(2)) u0 (
        .clk(clk), .rst(rst), .addr_in(addr), .data_in(din), .data_out(dout0),
        .read_q(rq), .write_q(wq), .read_dn(rdn0), .write_dn(wdn0),
        .rw_halt(halt), .bus_busy(busy0), .proto_err(perr0)
    );

    bus_mem_responder #(.BASE_ADDR(16'h0100), .DEPTH_LOG2(3), .WAIT_STATES(0)) u1 (
        .clk(clk), .rst(rst), .addr_in(addr), .data_in(din), .data_out(dout1),
        .read_q(rq), .write_q(wq), .read_dn(rdn1), .write_dn(wdn1),
        .rw_halt(halt), .bus_busy(busy1), .proto_err(perr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // A released net reads as z in a four-state simulator and as 0 in a two-state one.
    function automatic logic rel16(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    function automatic logic rel1(input logic v);
        return (v === 1'bz) || (v === 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        addr = a;
        din  = d;
        rq   = r;
        wq   = w;
        tick();
        rq = 1'b0;
        wq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; rq = 1'b0; wq = 1'b0; halt = 1'b0; addr = '0; din = '0;
        repeat (3) tick();
        check("rst_rdn",  32'(rdn0), 32'd0);
        check("rst_wdn",  32'(wdn0), 32'd0);
        check("rst_perr", 32'(perr0), 32'd0);
        check("rst_busy", 32'(rel1(busy0)), 32'd1);
        check("rst_dout", 32'(rel16(dout0)), 32'd1);
        rst = 1'b1;
        tick();

        // write 0x1234 at base+5, done pulse three edges after acceptance
        req(1'b0, 1'b1, 16'h0045, 16'h1234);
        check("wr_busy_wait", 32'(busy0), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("wr_dn_k%0d", k), 32'(wdn0), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) check("wr_busy_ack", 32'(busy0), 32'd1);
        end
        check("wr_busy_idle", 32'(rel1(busy0)), 32'd1);

        req(1'b1, 1'b0, 16'h0045, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rd_dn_k%0d", k), 32'(rdn0), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) check("rd_data", 32'(dout0), 32'h1234);
            else        check("rd_dout_rel", 32'(rel16(dout0)), 32'd1);
        end

        // halt in the first wait cycle kills the write
        req(1'b0, 1'b1, 16'h0045, 16'hBEEF);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_busy", 32'(rel1(busy0)), 32'd1);
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            npulse += int'(wdn0);
        end
        check("halt_no_wdn", 32'(npulse), 32'd0);
        req(1'b1, 1'b0, 16'h0045, 16'h0000);
        tick(); tick(); tick();
        check("halt_rd_dn", 32'(rdn0), 32'd1);
        check("halt_old_data", 32'(dout0), 32'h1234);
        tick();

        // one past the window
        req(1'b1, 1'b0, 16'h0050, 16'h0000);
        check("oow_busy", 32'(rel1(busy0)), 32'd1);
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            npulse += int'(rdn0);
        end
        check("oow_no_rdn", 32'(npulse), 32'd0);

        // halt in idle blocks acceptance
        halt = 1'b1;
        addr = 16'h0045;
        rq   = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        rq = 1'b0;
        check("idle_halt_busy", 32'(rel1(busy0)), 32'd1);
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            npulse += int'(rdn0);
        end
        check("idle_halt_no_rdn", 32'(npulse), 32'd0);

        // held request fires once
        addr = 16'h0045;
        rq   = 1'b1;
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            npulse += int'(rdn0);
        end
        rq = 1'b0;
        tick(); tick();
        check("held_one_pulse", 32'(npulse), 32'd1);

        // top index of the window
        req(1'b0, 1'b1, 16'h004F, 16'hA5A5);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) check("top_wr_dn", 32'(wdn0), 32'd1);
        end
`ifdef BUS_MEM_RESPONDER_WRPROT_EN
        check("top_prot_perr", 32'(perr0), 32'd1);
`else
        check("top_perr", 32'(perr0), 32'd0);
        req(1'b1, 1'b0, 16'h004F, 16'h0000);
        tick(); tick(); tick();
        check("top_rd_data", 32'(dout0), 32'hA5A5);
        tick();
`endif

        // zero-wait instance
        req(1'b0, 1'b1, 16'h0100, 16'h5A5A);
        tick();
        check("z_wr_dn", 32'(wdn1), 32'd1);
        check("z_u0_busy", 32'(rel1(busy0)), 32'd1);
        tick();
        check("z_wr_dn_end", 32'(wdn1), 32'd0);
        req(1'b1, 1'b0, 16'h0100, 16'h0000);
        check("z_rd_early", 32'(rdn1), 32'd0);
        check("z_dout_early", 32'(rel16(dout1)), 32'd1);
        tick();
        check("z_rd_dn", 32'(rdn1), 32'd1);
        check("z_rd_data", 32'(dout1), 32'h5A5A);
        tick();
        check("z_rd_dn_end", 32'(rdn1), 32'd0);
        check("z_dout_late", 32'(rel16(dout1)), 32'd1);
        tick();

        // simultaneous rising read and write
        req(1'b1, 1'b1, 16'h0045, 16'h0000);
        check("both_perr", 32'(perr0), 32'd1);
        npulse = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            npulse += int'(rdn0) + int'(wdn0);
        end
        check("both_no_pulse", 32'(npulse), 32'd0);
        check("both_perr_sticky", 32'(perr0), 32'd1);
        check("both_u1_perr", 32'(perr1), 32'd0);

        // reset mid-wait
        req(1'b1, 1'b0, 16'h0045, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_rdn",  32'(rdn0), 32'd0);
        check("mid_rst_wdn",  32'(wdn0), 32'd0);
        check("mid_rst_perr", 32'(perr0), 32'd0);
        check("mid_rst_busy", 32'(rel1(busy0)), 32'd1);
        check("mid_rst_dout", 32'(rel16(dout0)), 32'd1);
        rst = 1'b1;
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            npulse += int'(rdn0);
        end
        check("mid_rst_no_rdn", 32'(npulse), 32'd0);

        // memory survives reset
        req(1'b1, 1'b0, 16'h0045, 16'h0000);
        tick(); tick(); tick();
        check("post_rst_data", 32'(dout0), 32'h1234);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 0, SHALL set the first bus address of the responder window.
REQ-002 Parameter DEPTH_LOG2, default 8, SHALL set the window and storage size to 2^DEPTH_LOG2 words.
REQ-003 Parameter WAIT_STATES, default 2, SHALL set the number of wait cycles before a done pulse (range 0..15).
REQ-004 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 addr_in  input  `ADDR_SIZE  SHALL carry the requester's bus address.
REQ-007 data_in  input  `DATA_SIZE  SHALL carry the write data.
REQ-008 data_out  output  `DATA_SIZE  SHALL carry the read data while read_dn=1 and SHALL be high-impedance otherwise.
REQ-009 read_q / write_q  input  1 each  SHALL carry level read / write requests from the requester.
REQ-010 read_dn / write_dn  output  1 each  SHALL be single-cycle completion pulses.
REQ-011 rw_halt  input  1  SHALL be the bus abort; 1 cancels any transaction in flight.
REQ-012 bus_busy  output  1  SHALL be driven 1 while a transaction is owned and SHALL be high-impedance otherwise.
REQ-013 proto_err  output  1  SHALL be a sticky flag set on an illegal request.

Function
REQ-014 The responder SHALL implement a state machine with states IDLE, WAIT and ACK.
REQ-015 The window SHALL be the address range [BASE_ADDR, BASE_ADDR+2^DEPTH_LOG2-1]; the word index SHALL be addr_in-BASE_ADDR, truncated to DEPTH_LOG2 bits.
REQ-016 In IDLE, on a rising edge of exactly one of read_q or write_q (the signal was 0 in the previous cycle) with addr_in in the window, the responder SHALL latch the address, the direction and data_in, and go to WAIT.
REQ-017 In WAIT, a counter loaded with WAIT_STATES SHALL decrement each cycle; at 0 the FSM SHALL go to ACK (WAIT_STATES=0 SHALL pass through WAIT in one cycle).
REQ-018 Latency: for a request first sampled at edge N, the done pulse SHALL be high for exactly the cycle after edge N+WAIT_STATES+1.
REQ-019 In ACK for a read, the responder SHALL assert read_dn=1 for one cycle and drive data_out with mem[index]; it SHALL then return to IDLE.
REQ-020 In ACK for a write, the responder SHALL write mem[index]<=latched data on that edge, assert write_dn=1 for one cycle, and then return to IDLE.
REQ-021 bus_busy SHALL be 1 in WAIT and in ACK.
REQ-022 An out-of-window request SHALL be ignored: no state change, no done pulse, bus_busy stays high-impedance.
REQ-023 read_q and write_q rising in the same cycle in the window SHALL set proto_err, and the request SHALL be ignored.
REQ-024 A request that is still held after ACK SHALL NOT retrigger; a new request needs a 0 on that line for at least one cycle.
REQ-025 rw_halt=1 in WAIT or ACK SHALL return the FSM to IDLE on that edge, with no done pulse and no memory write.
REQ-026 rw_halt=1 in IDLE SHALL block request acceptance.
REQ-027 Requests arriving during WAIT or ACK SHALL be ignored, and their edges SHALL NOT be queued.

Reset
REQ-028 On rst=0 the responder SHALL be in IDLE, with read_dn=0, write_dn=0, proto_err=0, counter=0, data_out high-impedance and bus_busy high-impedance.
REQ-029 Reset SHALL NOT clear the memory contents.
REQ-030 Reset in the middle of a transaction SHALL abort it with no done pulse and no write.

Configuration
REQ-031 With BUS_MEM_RESPONDER_WRPROT_EN defined, the top 1/8 of the window SHALL be read-only: a write there SHALL produce write_dn but SHALL leave the memory unchanged, and proto_err SHALL be set.
REQ-032 Without BUS_MEM_RESPONDER_WRPROT_EN, the whole window SHALL be writable.

Verification
REQ-033 Write of 0x1234 at BASE_ADDR+5, then a read of the same address, with WAIT_STATES=2 -> write_dn pulses 3 cycles after the write_q edge; read_dn pulses with data_out=0x1234.
REQ-034 WAIT_STATES=0, read at BASE_ADDR -> read_dn in the cycle after the request edge; data_out is high-impedance in every other cycle.
REQ-035 Read at BASE_ADDR+2^DEPTH_LOG2 -> no read_dn, bus_busy high-impedance, FSM stays in IDLE.
REQ-036 read_q and write_q rising together -> proto_err=1, no done pulse, and proto_err still 1 after 10 cycles.
REQ-037 Write of 0xBEEF, rw_halt=1 in the first WAIT cycle, then a read of the same address -> no write_dn, and read_dn returns the old value.
REQ-038 read_q held high for 20 cycles -> exactly one read_dn pulse; rst=0 during WAIT -> no pulse and all outputs at their reset values.
